// File: rtl/uart_pkg.sv
// Types and helpers shared by the UART receive and transmit blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } rx_state_t;

    localparam logic EVEN_PAR      = 1'b0;
    localparam logic ODD_PAR       = 1'b1;
    localparam int   MAX_DATA_BITS = 9;

    // Parity bit a transmitter would send for this word; unused upper bits
    // are zero and do not affect the result.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic eo);
        return (^data) ^ eo;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Metastability synchroniser plus 3-sample majority filter for a serial line;
// the filtered output idles high out of reset.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rxd_i,
    output logic rxd_f_o
);

    logic r_sync1;
    logic r_sync2;
    logic r_hist0;
    logic r_hist1;
    logic r_rxd_f;

    // NOTE: every register here uses <= so each stage sees the previous
    // stage's value from before the edge, forming a true shift chain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist0 <= 1'b1;
            r_hist1 <= 1'b1;
            r_rxd_f <= 1'b1;
        end else begin
            r_sync1 <= rxd_i;
            r_sync2 <= r_sync1;
            r_hist0 <= r_sync2;
            r_hist1 <= r_hist0;
            r_rxd_f <= (r_sync2 & r_hist0) | (r_sync2 & r_hist1) | (r_hist0 & r_hist1);
        end
    end

    assign rxd_f_o = r_rxd_f;

endmodule

// File: rtl/uart_rx_flex.sv
// Parametrised UART receiver: oversampled framing FSM, parity/framing/break
// detection and a valid/ready holding register with overrun reporting.
module uart_rx_flex #(
    parameter int OVERSAMPLE_RATE = 16,
    parameter int DATA_BITS       = 8,
    parameter int PARITY_ON       = 1,
    parameter int PARITY_EO       = 1,
    parameter int STOP_BITS       = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 tick_i,
    input  logic                 rxd_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 overrun_o,
    output logic [2:0]           fsm_state_o
);

    import uart_pkg::*;

    localparam int TICK_W = $clog2(OVERSAMPLE_RATE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE_RATE - 1);
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE_RATE / 2 - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic              PAR_EO    = (PARITY_EO != 0) ? ODD_PAR : EVEN_PAR;

    rx_state_t            r_state;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_stop_err;
    logic                 r_stop0;
    logic                 r_done;
    logic                 r_done_perr;
    logic                 r_done_ferr;
    logic                 r_done_brk;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_break;
    logic                 r_overrun;

    logic w_rxd_f;
    logic w_bit_end;
    logic w_first_stop;
    logic w_is_break;
    logic w_par_err;
    logic w_frame_err;

    uart_rx_sync u_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rxd_i   (rxd_i),
        .rxd_f_o (w_rxd_f)
    );

    // Mid-bit sample point: the tick counter is about to wrap.
    assign w_bit_end    = (r_tick_cnt == TICK_LAST);
    assign w_first_stop = (r_bit_cnt == '0) ? w_rxd_f : r_stop0;
    assign w_is_break   = (r_shift == '0) && ((PARITY_ON == 0) || !r_par_bit) && !w_first_stop;
    assign w_par_err    = (PARITY_ON != 0) &&
                          (calc_parity(MAX_DATA_BITS'(r_shift), PAR_EO) != r_par_bit);
    assign w_frame_err  = r_stop_err | ~w_rxd_f;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_stop_err  <= 1'b0;
            r_stop0     <= 1'b0;
            r_done      <= 1'b0;
            r_done_perr <= 1'b0;
            r_done_ferr <= 1'b0;
            r_done_brk  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (tick_i) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_rxd_f) begin
                            r_state    <= ST_START;
                            r_tick_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (r_tick_cnt == HALF_LAST) begin
                            r_tick_cnt <= '0;
                            r_bit_cnt  <= '0;
                            r_par_bit  <= 1'b0;
                            r_stop_err <= 1'b0;
                            r_state    <= w_rxd_f ? ST_IDLE : ST_DATA;
                        end else begin
                            r_tick_cnt <= r_tick_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                        if (w_bit_end) begin
                            r_shift <= {w_rxd_f, r_shift[DATA_BITS-1:1]};
                            if (r_bit_cnt == DATA_LAST) begin
                                r_bit_cnt <= '0;
                                r_state   <= (PARITY_ON != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                        if (w_bit_end) begin
                            r_par_bit <= w_rxd_f;
                            r_state   <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                        if (w_bit_end) begin
                            if (r_bit_cnt == '0) r_stop0 <= w_rxd_f;
                            if (!w_rxd_f) r_stop_err <= 1'b1;
                            // Leave at mid-bit so the next start edge is seen in time.
                            if (r_bit_cnt == STOP_LAST) begin
                                r_done      <= 1'b1;
                                r_done_perr <= w_par_err;
                                r_done_ferr <= w_frame_err;
                                r_done_brk  <= w_is_break;
                                r_state     <= w_is_break ? ST_BREAK_WAIT : ST_IDLE;
                                r_tick_cnt  <= '0;
                                r_bit_cnt   <= '0;
                                r_stop_err  <= 1'b0;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                            end
                        end
                    end
                    ST_BREAK_WAIT: begin
                        if (w_rxd_f) r_state <= ST_IDLE;
                    end
                    default: begin
                        r_state    <= ST_IDLE;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
                endcase
            end
        end
    end

    // Holding register: a completed frame loads if the slot is free or being
    // drained this cycle, otherwise it is dropped and flagged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done) begin
                if (!r_rx_valid || rx_ready_i) begin
                    r_rx_data    <= r_shift;
                    r_parity_err <= r_done_perr;
                    r_frame_err  <= r_done_ferr;
                    r_break      <= r_done_brk;
                    r_rx_valid   <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready_i) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data_o    = r_rx_data;
    assign rx_valid_o   = r_rx_valid;
    assign parity_err_o = r_parity_err;
    assign frame_err_o  = r_frame_err;
    assign break_o      = r_break;
    assign overrun_o    = r_overrun;
    assign fsm_state_o  = r_state;

endmodule

// File: tb/tb_uart_rx_flex.sv
// Bench for uart_rx_flex: table of directed frames, hand-written corner cases
// and random frames checked against a frame-level reference model.
module tb_uart_rx_flex;

    localparam int OS_A  = 16;
    localparam int OS_B  = 8;
    localparam int TDIV  = 4;
    localparam int BIT_A = OS_A * TDIV;
    localparam int BIT_B = OS_B * TDIV;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } word_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    logic clk = 1'b0;
    logic tick = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rxd_a = 1'b1;
    logic rxd_b = 1'b1;
    logic ready_a = 1'b0;
    logic ready_b = 1'b1;
    logic ready_rand = 1'b0;
    logic random_mode = 1'b0;
    logic ready_a_pin;

    logic [7:0] data_a;
    logic       valid_a, perr_a, ferr_a, brk_a, ovr_a;
    logic [2:0] state_a;
    logic [4:0] data_b;
    logic       valid_b, perr_b, ferr_b, brk_b, ovr_b;
    logic [2:0] state_b;

    int n_vec = 0;
    int n_err = 0;
    int tick_div = 0;
    int ovr_cnt_a = 0;
    int ovr_cnt_b = 0;
    word_t exp_q[$];
    logic [7:0] got_b[$];

    assign ready_a_pin = random_mode ? ready_rand : ready_a;

    uart_rx_flex #(.OVERSAMPLE_RATE(OS_A), .DATA_BITS(8), .PARITY_ON(1),
                   .PARITY_EO(1), .STOP_BITS(1)) u_dut_a (
        .clk_i(clk), .rst_i(rst_a), .tick_i(tick), .rxd_i(rxd_a),
        .rx_data_o(data_a), .rx_valid_o(valid_a), .rx_ready_i(ready_a_pin),
        .parity_err_o(perr_a), .frame_err_o(ferr_a), .break_o(brk_a),
        .overrun_o(ovr_a), .fsm_state_o(state_a)
    );

    uart_rx_flex #(.OVERSAMPLE_RATE(OS_B), .DATA_BITS(5), .PARITY_ON(0),
                   .PARITY_EO(0), .STOP_BITS(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst_b), .tick_i(tick), .rxd_i(rxd_b),
        .rx_data_o(data_b), .rx_valid_o(valid_b), .rx_ready_i(ready_b),
        .parity_err_o(perr_b), .frame_err_o(ferr_b), .break_o(brk_b),
        .overrun_o(ovr_b), .fsm_state_o(state_b)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        tick_div = (tick_div + 1) % TDIV;
        tick = (tick_div == 0);
        if (ovr_a) ovr_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
        if (valid_b && ready_b) got_b.push_back({perr_b, ferr_b, brk_b, data_b});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: what a receiver must report for the given line bits.
    function automatic word_t ref_frame(input int db, input int pon, input int eo,
                                        input logic [8:0] data, input logic par,
                                        input logic [1:0] stops, input int nstop);
        word_t w;
        logic [8:0] d;
        int ones;
        d = data & 9'((1 << db) - 1);
        ones = $countones(d);
        w.data = d;
        w.perr = (pon != 0) && (((ones + int'(par)) % 2) != eo);
        w.ferr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
        w.brk  = (d == 0) && (pon == 0 || par == 1'b0) && (stops[0] == 1'b0);
        return w;
    endfunction

    always @(negedge clk) begin
        word_t w;
        if (random_mode) begin
            ready_rand = ($urandom % 2) == 1;
            if (valid_a && ready_rand) begin
                check("rand word expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("rand data", 32'(data_a), 32'(w.data));
                    check("rand perr", 32'(perr_a), 32'(w.perr));
                    check("rand ferr", 32'(ferr_a), 32'(w.ferr));
                    check("rand brk",  32'(brk_a),  32'(w.brk));
                end
            end
        end
    end

    task automatic line_a(input logic v, input int cycles);
        @(negedge clk);
        rxd_a = v;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic line_b(input logic v, input int cycles);
        @(negedge clk);
        rxd_b = v;
        repeat (cycles - 1) @(negedge clk);
    endtask

    task automatic send_a(input logic [7:0] data, input logic par, input logic stop);
        logic [10:0] bits;
        bits = {stop, par, data, 1'b0};
        for (int i = 0; i < 11; i++) line_a(bits[i], BIT_A);
    endtask

    task automatic send_b(input logic [4:0] data);
        logic [7:0] bits;
        bits = {2'b11, data, 1'b0};
        for (int i = 0; i < 8; i++) line_b(bits[i], BIT_B);
    endtask

    task automatic wait_valid_a(input string name);
        int n = 0;
        while (!valid_a && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(valid_a), 32'd1);
    endtask

    task automatic drain_a(input string name);
        @(negedge clk);
        ready_a = 1'b1;
        @(negedge clk);
        ready_a = 1'b0;
        check(name, 32'(valid_a), 32'd0);
    endtask

    vec_t tbl[7];

    initial begin
        word_t w;
        int ovr_base;
        logic seen_start, seen_data, found;
        logic [7:0] d;
        logic p, s;

        tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h55, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

        repeat (5) @(negedge clk);
        check("reset data_a",  32'(data_a),  32'd0);
        check("reset valid_a", 32'(valid_a), 32'd0);
        check("reset flags_a", 32'({perr_a, ferr_a, brk_a, ovr_a}), 32'd0);
        check("reset state_a", 32'(state_a), 32'd0);
        check("reset data_b",  32'(data_b),  32'd0);
        check("reset valid_b", 32'(valid_b), 32'd0);
        check("reset state_b", 32'(state_b), 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (20) @(negedge clk);

        // Directed frames: valid must hold until the consumer takes the word.
        for (int i = 0; i < 7; i++) begin
            ready_a = 1'b0;
            send_a(tbl[i].data, tbl[i].par, tbl[i].stop);
            line_a(1'b1, BIT_A);
            wait_valid_a($sformatf("tbl%0d valid", i));
            check($sformatf("tbl%0d data", i), 32'(data_a), 32'(tbl[i].exp_data));
            check($sformatf("tbl%0d perr", i), 32'(perr_a), 32'(tbl[i].exp_perr));
            check($sformatf("tbl%0d ferr", i), 32'(ferr_a), 32'(tbl[i].exp_ferr));
            check($sformatf("tbl%0d brk", i),  32'(brk_a),  32'(tbl[i].exp_brk));
            check($sformatf("tbl%0d idle", i), 32'(state_a), 32'd0);
            drain_a($sformatf("tbl%0d drained", i));
        end

        // Short low glitch: START entered, abandoned, nothing delivered.
        seen_start = 1'b0;
        seen_data  = 1'b0;
        line_a(1'b0, 3 * TDIV);
        rxd_a = 1'b1;
        repeat (2 * BIT_A) begin
            @(negedge clk);
            if (state_a == 3'd1) seen_start = 1'b1;
            if (state_a == 3'd2) seen_data = 1'b1;
        end
        check("glitch saw start", 32'(seen_start), 32'd1);
        check("glitch no data",   32'(seen_data),  32'd0);
        check("glitch idle",      32'(state_a),    32'd0);
        check("glitch no valid",  32'(valid_a),    32'd0);

        // Line held low for two frame times.
        w = ref_frame(8, 1, 1, 9'h000, 1'b0, 2'b00, 1);
        line_a(1'b0, 22 * BIT_A);
        check("break valid", 32'(valid_a), 32'd1);
        check("break data",  32'(data_a),  32'(w.data));
        check("break brk",   32'(brk_a),   32'(w.brk));
        check("break ferr",  32'(ferr_a),  32'(w.ferr));
        check("break perr",  32'(perr_a),  32'(w.perr));
        check("break wait",  32'(state_a), 32'd5);
        line_a(1'b1, 2 * BIT_A);
        check("break exit",  32'(state_a), 32'd0);
        drain_a("break drained");

        // Overrun: second word dropped, first kept, single-cycle pulse.
        ovr_base = ovr_cnt_a;
        send_a(8'h11, 1'b1, 1'b1);
        send_a(8'h22, 1'b1, 1'b1);
        line_a(1'b1, BIT_A);
        check("ovr valid", 32'(valid_a), 32'd1);
        check("ovr held data", 32'(data_a), 32'h11);
        check("ovr pulse count", 32'(ovr_cnt_a - ovr_base), 32'd1);
        drain_a("ovr drained");

        // Transfer on the completion cycle: new word loads, no overrun.
        ovr_base = ovr_cnt_a;
        send_a(8'h11, 1'b1, 1'b1);
        found = 1'b0;
        fork
            send_a(8'h22, 1'b1, 1'b1);
            begin
                int n = 0;
                while (!u_dut_a.r_done && n < 2000) begin
                    @(negedge clk);
                    n++;
                end
                found = u_dut_a.r_done;
                ready_a = 1'b1;
                @(negedge clk);
                ready_a = 1'b0;
            end
        join
        line_a(1'b1, BIT_A);
        check("sim completion seen", 32'(found), 32'd1);
        check("sim valid", 32'(valid_a), 32'd1);
        check("sim data", 32'(data_a), 32'h22);
        check("sim no overrun", 32'(ovr_cnt_a - ovr_base), 32'd0);
        drain_a("sim drained");

        // Random frames checked against the frame model.
        ovr_base = ovr_cnt_a;
        random_mode = 1'b1;
        for (int i = 0; i < 25; i++) begin
            d = 8'($urandom);
            p = 1'(($countones(d) + 1) % 2);
            if ($urandom % 4 == 0) p = ~p;
            s = ($urandom % 8) != 0;
            if ($urandom % 10 == 0) begin
                d = 8'h00;
                p = 1'b0;
                s = 1'b0;
            end
            exp_q.push_back(ref_frame(8, 1, 1, {1'b0, d}, p, {1'b1, s}, 1));
            send_a(d, p, s);
            if (!s || ($urandom % 2) == 1) line_a(1'b1, BIT_A);
        end
        line_a(1'b1, BIT_A);
        for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(negedge clk);
        check("rand all words received", 32'(exp_q.size()), 32'd0);
        check("rand no overrun", 32'(ovr_cnt_a - ovr_base), 32'd0);
        random_mode = 1'b0;

        // Narrow configuration: two back-to-back frames, two stop bits.
        send_b(5'h1F);
        send_b(5'h0A);
        line_b(1'b1, BIT_B);
        for (int n = 0; n < 1000 && got_b.size() < 2; n++) @(negedge clk);
        check("sweep count", 32'(got_b.size()), 32'd2);
        if (got_b.size() >= 2) begin
            check("sweep word0", 32'(got_b[0]), 32'h1F);
            check("sweep word1", 32'(got_b[1]), 32'h0A);
        end
        check("sweep no overrun", 32'(ovr_cnt_b), 32'd0);

        // Reset in the middle of DATA aborts the frame.
        line_b(1'b0, BIT_B);
        line_b(1'b1, BIT_B);
        line_b(1'b0, BIT_B / 2);
        check("rst mid state data", 32'(state_b), 32'd2);
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst state idle", 32'(state_b), 32'd0);
        check("rst valid low", 32'(valid_b), 32'd0);
        rst_b = 1'b0;
        rxd_b = 1'b1;
        repeat (12 * BIT_B) @(negedge clk);
        check("rst no word", 32'(got_b.size()), 32'd2);
        check("rst still idle", 32'(state_b), 32'd0);
        check("rst flags clear", 32'({perr_b, ferr_b, brk_b, valid_b}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
